// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the multi-channel PWM generator.
package pwm_pkg;
  localparam int WIDTH_DEF = 22;
  localparam int CHANNELS_DEF = 4;
  localparam logic MODO_EDGE = 1'b0;
  localparam logic MODO_CENTER = 1'b1;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;
endpackage

// File: rtl/pwm_multicanal_if.sv
// pwm_multicanal_if: duty-value write port from the control logic.
interface pwm_multicanal_if import pwm_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic dato_wr;
  logic [3:0] canal;
  logic [WIDTH-1:0] dato;
  modport master(output dato_wr, canal, dato);
  modport slave(input dato_wr, canal, dato);
endinterface

// File: rtl/pwm_canal.sv
// pwm_canal: one channel with double-buffered duty and registered compare.
module pwm_canal import pwm_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             boundary,
  input  logic             dato_wr,
  input  logic [3:0]       canal,
  input  logic [WIDTH-1:0] dato,
  input  logic [WIDTH-1:0] counter,
  output logic             pwm
);
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] active;
  // a write landing on the boundary edge goes to pending only, so it waits one more period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
      pwm     <= 1'b0;
    end else begin
      if (dato_wr && canal == 4'(IDX)) pending <= dato;
      if (boundary) active <= pending;
      pwm <= enable && counter < active;
    end
endmodule

// File: rtl/pwm_multicanal.sv
// pwm_multicanal: shared period counter (edge/center aligned) driving CHANNELS
// glitch-free comparators whose duty and period reload only at period boundaries.
module pwm_multicanal import pwm_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHANNELS = CHANNELS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                modo,
  input  logic [WIDTH-1:0]    periodo,
  pwm_multicanal_if.slave     bus,
  output logic [CHANNELS-1:0] pwm,
  output logic [WIDTH-1:0]    counter,
  output logic                period_tick
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  dir_t dir, dir_nxt;
  logic [WIDTH-1:0] p_act, cnt_nxt;
  logic mode_act, en_d, boundary, center_wrap;
  // center mode wraps when the next count would be 0, which includes P=1 at the top
  always_comb begin
    center_wrap = p_act == '0 || (counter == ONE && (dir == DOWN || p_act == ONE));
    boundary = enable && (!en_d || (mode_act == MODO_CENTER ? center_wrap : counter == p_act));
    dir_nxt = dir;
    cnt_nxt = counter + ONE;
    if (!enable || boundary) begin
      cnt_nxt = '0;
      dir_nxt = UP;
    end else if (mode_act == MODO_CENTER && (dir == DOWN || counter == p_act)) begin
      cnt_nxt = counter - ONE;
      dir_nxt = DOWN;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      counter     <= '0;
      dir         <= UP;
      en_d        <= 1'b0;
      period_tick <= 1'b0;
      p_act       <= '0;
      mode_act    <= MODO_EDGE;
    end else begin
      counter     <= cnt_nxt;
      dir         <= dir_nxt;
      en_d        <= enable;
      period_tick <= boundary;
      if (boundary) begin
        p_act    <= periodo;
        mode_act <= modo;
      end
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_canal
    pwm_canal #(.WIDTH(WIDTH), .IDX(i)) u_canal (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .boundary(boundary),
      .dato_wr(bus.dato_wr),
      .canal(bus.canal),
      .dato(bus.dato),
      .counter(counter),
      .pwm(pwm[i])
    );
  end
endmodule
